// File: rtl/tty_uart_tx.sv
// TTY character sink: buffers 7-bit characters from the core in a small FIFO
// and serialises each one as an 8N1 UART frame on tx_o.
module tty_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_in,
  input  logic [6:0]                       tty_i,
  input  logic                             tty_we_i,
  output logic                             tx_o,
  output logic                             busy_o,
  output logic                             full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
  output logic                             ovf_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   count;
  logic [BAUD_W-1:0]  baud, baud_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic [7:0]         sh, sh_nxt;
  logic               baud_end, pop, push, ovf_nxt, tx_nxt;

  assign full_o   = (count == LVL_FULL);
  assign level_o  = count;
  assign busy_o   = (state != IDLE) || (count != '0);
  assign baud_end = (baud == BAUD_LAST);

  // A pop frees a slot on the same edge, so a write to a full FIFO is still taken then.
  assign pop     = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_end));
  assign push    = tty_we_i && (!full_o || pop);
  assign ovf_nxt = tty_we_i && full_o && !pop;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf_o <= ovf_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {1'b0, tty_i};
  end

  // State register; tx_o is registered from the next-state decode
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      tx_o    <= tx_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    sh <= sh_nxt;
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_end ? '0 : baud + 1'b1;
    bit_idx_nxt = bit_idx;
    sh_nxt      = sh;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (pop) begin
          state_nxt = START;
          sh_nxt    = mem[rd_ptr];
        end
      end
      START: begin
        if (baud_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            sh_nxt      = {1'b0, sh[7:1]};
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (pop) begin
            state_nxt = START;
            sh_nxt    = mem[rd_ptr];
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tty_uart_tx.sv
// Directed bench for tty_uart_tx: a line monitor decodes frames and compares
// them against a queue of characters expected to reach the line.
module tb_tty_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_in = 1'b0;
  logic [6:0]    tty_i = '0;
  logic          tty_we_i = 1'b0;
  logic          tx_o, busy_o, full_o, ovf_o;
  logic [LW-1:0] level_o;

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_seen = 1'b0;
  logic [7:0] exp_q[$];
  int   starts_q[$];

  tty_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .tty_i(tty_i), .tty_we_i(tty_we_i),
    .tx_o(tx_o), .busy_o(busy_o), .full_o(full_o), .level_o(level_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge rst_in) rst_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one write for the next rising edge.
  task automatic put(input logic [6:0] c);
    @(negedge clk_i);
    tty_i    = c;
    tty_we_i = 1'b1;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && t < budget) begin
      @(posedge clk_i);
      t++;
    end
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_busy_low", busy_o, 0);
  endtask

  // Line monitor: samples each bit at its centre on the falling clock edge.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] expv;
    logic       stb, spb;
    forever begin
      @(negedge clk_i);
      if (rst_in === 1'b1 && tx_o === 1'b0) begin
        rst_seen = 1'b0;
        starts_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk_i);
        stb = tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_i);
          got[i] = tx_o;
        end
        repeat (CPB) @(negedge clk_i);
        spb = tx_o;
        if (!rst_seen) begin
          chk("frame_was_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            expv = exp_q.pop_front();
            chk("frame_bits", {stb, got, spb}, {1'b0, expv, 1'b1});
          end
        end
      end
    end
  end

  initial begin : stim
    int bad;
    int c1;
    int ovf_cnt;

    // Reset and idle line
    #10;
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", ovf_o, 0);
    #11 rst_in = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(posedge clk_i); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== '0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // Single character 'A'
    put(7'h41);
    exp_q.push_back(8'h41);
    @(posedge clk_i); #1;
    tty_we_i = 1'b0;
    chk("single_level_after_write", level_o, 1);
    chk("single_tx_high_at_write", tx_o, 1);
    chk("single_busy_at_write", busy_o, 1);
    @(posedge clk_i); #1;
    chk("single_tx_start", tx_o, 0);
    chk("single_level_after_pop", level_o, 0);
    repeat (39) @(posedge clk_i);
    #1;
    chk("single_busy_end_of_frame", busy_o, 1);
    @(posedge clk_i); #1;
    chk("single_busy_falls", busy_o, 0);
    chk("single_tx_idle", tx_o, 1);
    drain(200);

    // Burst "Hi!" on consecutive cycles
    starts_q.delete();
    put(7'h48); exp_q.push_back(8'h48);
    @(posedge clk_i); #1;
    chk("burst_level0", level_o, 1);
    put(7'h69); exp_q.push_back(8'h69);
    @(posedge clk_i); #1;
    chk("burst_level1", level_o, 1);
    put(7'h21); exp_q.push_back(8'h21);
    @(posedge clk_i); #1;
    tty_we_i = 1'b0;
    chk("burst_level_peak", level_o, 2);
    drain(400);
    chk("burst_frames", starts_q.size(), 3);
    chk("burst_gap01", starts_q[1] - starts_q[0], 10 * CPB);
    chk("burst_gap12", starts_q[2] - starts_q[1], 10 * CPB);

    // Overflow: ten writes from idle, the tenth is dropped
    ovf_cnt = 0;
    c1 = 0;
    for (int i = 0; i < 10; i++) begin
      put(7'(7'h30 + i));
      if (i < 9) exp_q.push_back(8'(8'h30 + i));
      @(posedge clk_i); #1;
      if (i == 1) c1 = cyc;
      if (ovf_o === 1'b1) ovf_cnt++;
      if (i == 8) chk("ovf_full_before_10th", full_o, 1);
      if (i == 9) begin
        chk("ovf_pulse_on_10th", ovf_o, 1);
        chk("ovf_level_stays_full", level_o, DEPTH);
      end
    end
    tty_we_i = 1'b0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (ovf_o === 1'b1) ovf_cnt++;
    end
    chk("ovf_single_pulse", ovf_cnt, 1);

    // Full plus simultaneous pop at the end of the first frame's stop bit
    repeat (c1 + 39 - cyc) @(posedge clk_i);
    #1;
    chk("fullpop_full_before", full_o, 1);
    put(7'h5a);
    exp_q.push_back(8'h5a);
    @(posedge clk_i); #1;
    tty_we_i = 1'b0;
    chk("fullpop_no_ovf", ovf_o, 0);
    chk("fullpop_level", level_o, DEPTH);
    chk("fullpop_next_start", tx_o, 0);
    drain(1000);

    // Reset during data bit 3 with five characters queued
    for (int i = 0; i < 6; i++) begin
      put(7'(7'h30 + i));
      exp_q.push_back(8'(8'h30 + i));
      @(posedge clk_i); #1;
      if (i == 1) c1 = cyc;
    end
    tty_we_i = 1'b0;
    repeat (c1 + 17 - cyc) @(posedge clk_i);
    #1;
    chk("midrst_tx_in_bit3", tx_o, 0);
    chk("midrst_level_queued", level_o, 5);
    #2 rst_in = 1'b0;
    #1;
    chk("midrst_tx_async", tx_o, 1);
    chk("midrst_level_async", level_o, 0);
    chk("midrst_busy_async", busy_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_in = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge clk_i); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== '0) bad++;
    end
    chk("midrst_line_stays_idle", bad, 0);
    put(7'h55);
    exp_q.push_back(8'h55);
    @(posedge clk_i); #1;
    tty_we_i = 1'b0;
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tty_uart_tx.md
Name: tty_uart_tx

Overview:
- Downstream consumer of the MCU's TTY port: captures each 7-bit character written by the core and transmits it as an 8N1 UART frame on a single serial line.
- Sits between the mcu instance and the board-level TX pin (or the bench's serial monitor).
- A small FIFO absorbs bursts, because the core writes characters far faster than the line can send them.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; integer >= 2.
- FIFO_DEPTH, 8: character buffer entries; power of two, >= 2.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous active-low reset.
- tty_i  input  7  ASCII character from the core.
- tty_we_i  input  1  write strobe; each cycle high with a rising clk_i edge is one write of tty_i.
- tx_o  output  1  UART serial out; idle high.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- full_o  output  1  FIFO holds FIFO_DEPTH entries.
- level_o  output  $clog2(FIFO_DEPTH+1)  number of entries in the FIFO (excludes the frame in flight).
- ovf_o  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async, rst_in=0):
  - tx_o=1, busy_o=0, full_o=0, level_o=0, ovf_o=0.
  - FIFO pointers cleared; FSM=IDLE; bit and baud counters = 0.
  - Reset asserted mid-frame aborts the frame immediately and discards buffered characters. No partial frame resumes after release.
- FIFO:
  - Circular buffer with read/write pointers of width log2(FIFO_DEPTH) that wrap naturally, plus a separate count register.
  - Stored word = {1'b0, tty_i} (8 bits, MSB 0).
  - Write when not full: store the word, advance the write pointer, count+1.
  - Write when full and no pop on the same edge: the data is dropped and ovf_o is high for exactly the following cycle. FIFO contents are unchanged.
  - Write and pop on the same edge: both take effect and the count is unchanged. This holds when full (the write is accepted, no ovf) and when count=1.
  - Write while empty and IDLE: the data enters the FIFO and is popped on the next edge (no bypass path).
- FSM states IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx_o=1. If count>0: pop into shift register sh[7:0], go to START, reset the baud counter.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o=sh[0], LSB first, 8 bits of CLKS_PER_BIT cycles each. Shift right at each bit boundary. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START (back-to-back frames, no extra idle cycle); otherwise go to IDLE.
  - tx_o is a registered output (glitch-free).
- Latency and timing:
  - A write captured at edge E into an empty FIFO with FSM in IDLE is popped at E+1. tx_o falls after edge E+1.
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
  - Consecutive frames from a backlog are spaced exactly 10*CLKS_PER_BIT cycles start-to-start.
- busy_o = (state!=IDLE) | (count!=0). full_o = (count==FIFO_DEPTH). level_o = count. All are registered or derived from registered state only.
- No backpressure to the core: the core cannot be stalled, so overflow is reported, never blocked.

Test Plan:
- Reset/idle: rst_in low 21 ns, then high, no writes -> tx_o=1, busy_o=0, level_o=0 for 1000 cycles.
- Single char, CLKS_PER_BIT=4: one-cycle write of 0x41 ('A') -> tx_o goes low one cycle after the write edge. Sampled mid-bit, the sequence is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles. busy_o falls after cycle 40 of the frame.
- Burst: write "Hi!" (0x48,0x69,0x21) on 3 consecutive cycles -> level_o peaks at 2. Three frames are sent back-to-back with no idle gap (start bits 40 cycles apart), bytes decode to 0x48,0x69,0x21.
- Overflow, FIFO_DEPTH=8: write 10 chars on consecutive cycles starting from idle.
  - The first is popped immediately and 8 are stored.
  - The 10th write sees full_o=1 -> ovf_o pulses exactly once and is dropped.
  - The line transmits chars 1..9 in order.
- Full plus simultaneous pop: with full_o=1 and the FSM ending STOP, write on the pop edge -> the write is accepted, no ovf_o, and level_o stays 8.
- Reset mid-frame: assert rst_in during DATA bit 3 with 5 chars queued -> tx_o=1 immediately (asynchronous), level_o=0. After release the line stays idle until a new write.
